// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Counts per-note hits and misses from the dropper array, tracks
//             score, combo and max combo, and runs the Idle/Play/Done song flow.
//  Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int NUM_NOTES      = 64,
    parameter int POINTS_PER_HIT = 10,
    parameter int SCORE_MAX      = 9999,
    parameter int SONG_FRAMES    = 4096
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [7:0]           keycode_second,
    input  logic [NUM_NOTES-1:0] score_vec,
    input  logic [NUM_NOTES-1:0] miss_vec,
    output logic [15:0]          score_bcd,
    output logic [11:0]          hit_count,
    output logic [11:0]          combo,
    output logic [11:0]          max_combo,
    output logic                 play_active,
    output logic                 game_over
);

    localparam int c_CNT_W = $clog2(NUM_NOTES + 1);
    localparam int c_TMR_W = (SONG_FRAMES > 1) ? $clog2(SONG_FRAMES) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PLAY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(SONG_FRAMES - 1);
    localparam logic [13:0]        c_SCORE_MAX = 14'(SCORE_MAX);

    logic [1:0]           r_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [NUM_NOTES-1:0] r_score_prev;
    logic [NUM_NOTES-1:0] r_miss_prev;
    logic [13:0]          r_score;
    logic [11:0]          r_hit_count;
    logic [11:0]          r_combo;
    logic [11:0]          r_max_combo;

    logic                 w_key_start;
    logic                 w_key_stop;
    logic [NUM_NOTES-1:0] w_hit_edge;
    logic [NUM_NOTES-1:0] w_miss_edge;
    logic [c_CNT_W-1:0]   w_h;
    logic [c_CNT_W-1:0]   w_m;
    logic [12:0]          w_hit_sum;
    logic [12:0]          w_combo_sum;
    logic [11:0]          w_hit_next;
    logic [11:0]          w_combo_next;
    logic [11:0]          w_max_next;
    logic [31:0]          w_score_sum;
    logic [13:0]          w_score_next;
    logic [29:0]          w_dd;

    assign w_key_start = (keycode == 8'h2c) || (keycode_second == 8'h2c);
    assign w_key_stop  = (keycode == 8'h01) || (keycode_second == 8'h01);

    assign w_hit_edge  = score_vec & ~r_score_prev;
    assign w_miss_edge = miss_vec & ~r_miss_prev;

    always_comb begin
        w_h = '0;
        w_m = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            w_h = w_h + c_CNT_W'(w_hit_edge[i]);
            w_m = w_m + c_CNT_W'(w_miss_edge[i]);
        end
    end

    // Any miss this frame breaks the run, even if hits landed alongside it.
    assign w_hit_sum    = {1'b0, r_hit_count} + 13'(w_h);
    assign w_combo_sum  = {1'b0, r_combo} + 13'(w_h);
    assign w_hit_next   = w_hit_sum[12] ? 12'hFFF : w_hit_sum[11:0];
    assign w_combo_next = (w_m != '0) ? 12'd0 :
                          (w_combo_sum[12] ? 12'hFFF : w_combo_sum[11:0]);
    assign w_max_next   = (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;

    assign w_score_sum  = 32'(r_score) + 32'(w_h) * 32'(POINTS_PER_HIT);
    assign w_score_next = (w_score_sum > 32'(SCORE_MAX)) ? c_SCORE_MAX : w_score_sum[13:0];

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= c_ST_IDLE;
            r_timer      <= '0;
            r_score_prev <= '0;
            r_miss_prev  <= '0;
            r_score      <= '0;
            r_hit_count  <= '0;
            r_combo      <= '0;
            r_max_combo  <= '0;
        end else begin
            r_score_prev <= score_vec;
            r_miss_prev  <= miss_vec;
            case (r_state)
                c_ST_IDLE: begin
                    r_timer     <= '0;
                    r_score     <= '0;
                    r_hit_count <= '0;
                    r_combo     <= '0;
                    r_max_combo <= '0;
                    if (w_key_start) begin
                        r_state <= c_ST_PLAY;
                    end
                end
                c_ST_PLAY: begin
                    r_score     <= w_score_next;
                    r_hit_count <= w_hit_next;
                    r_combo     <= w_combo_next;
                    r_max_combo <= w_max_next;
                    if (r_timer == c_TMR_LAST) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    if (w_key_stop) begin
                        r_state     <= c_ST_IDLE;
                        r_score     <= '0;
                        r_hit_count <= '0;
                        r_combo     <= '0;
                        r_max_combo <= '0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Shift-and-add-3 binary to BCD over the 14-bit score.
    always_comb begin
        w_dd = {16'b0, r_score};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (w_dd[14 + 4*d +: 4] >= 4'd5) begin
                    w_dd[14 + 4*d +: 4] = w_dd[14 + 4*d +: 4] + 4'd3;
                end
            end
            w_dd = w_dd << 1;
        end
    end

    assign score_bcd   = w_dd[29:14];
    assign hit_count   = r_hit_count;
    assign combo       = r_combo;
    assign max_combo   = r_max_combo;
    assign play_active = (r_state == c_ST_PLAY);
    assign game_over   = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_keeper
//  Purpose  : Directed self-checking bench for score_keeper (long-song and
//             16-frame-song instances sharing one stimulus stream).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [7:0]  keycode;
    logic [7:0]  keycode_second;
    logic [63:0] score_vec;
    logic [63:0] miss_vec;

    logic [15:0] w_bcd_a;
    logic [11:0] w_hit_a, w_combo_a, w_max_a;
    logic        w_play_a, w_over_a;

    logic [15:0] w_bcd_b;
    logic [11:0] w_hit_b, w_combo_b, w_max_b;
    logic        w_play_b, w_over_b;

    int r_checks = 0;
    int r_fails  = 0;

    always #5 frame_clk = ~frame_clk;

    score_keeper #(.NUM_NOTES(64), .POINTS_PER_HIT(10), .SCORE_MAX(9999), .SONG_FRAMES(4096)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
        .score_vec(score_vec), .miss_vec(miss_vec), .score_bcd(w_bcd_a), .hit_count(w_hit_a),
        .combo(w_combo_a), .max_combo(w_max_a), .play_active(w_play_a), .game_over(w_over_a)
    );

    score_keeper #(.NUM_NOTES(64), .POINTS_PER_HIT(10), .SCORE_MAX(9999), .SONG_FRAMES(16)) dut_short (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
        .score_vec(score_vec), .miss_vec(miss_vec), .score_bcd(w_bcd_b), .hit_count(w_hit_b),
        .combo(w_combo_b), .max_combo(w_max_b), .play_active(w_play_b), .game_over(w_over_b)
    );

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        assert (obs === exp) else begin
            r_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [15:0] bcd, input logic [11:0] hit,
                           input logic [11:0] cmb, input logic [11:0] mx);
        check({tag, ".bcd"},   32'(w_bcd_a),   32'(bcd));
        check({tag, ".hit"},   32'(w_hit_a),   32'(hit));
        check({tag, ".combo"}, 32'(w_combo_a), 32'(cmb));
        check({tag, ".max"},   32'(w_max_a),   32'(mx));
    endtask

    task automatic check_b(input string tag, input logic [15:0] bcd, input logic [11:0] hit,
                           input logic [11:0] cmb, input logic [11:0] mx,
                           input logic play, input logic over);
        check({tag, ".bcd"},   32'(w_bcd_b),   32'(bcd));
        check({tag, ".hit"},   32'(w_hit_b),   32'(hit));
        check({tag, ".combo"}, 32'(w_combo_b), 32'(cmb));
        check({tag, ".max"},   32'(w_max_b),   32'(mx));
        check({tag, ".play"},  32'(w_play_b),  32'(play));
        check({tag, ".over"},  32'(w_over_b),  32'(over));
    endtask

    initial begin
        Reset          = 1'b1;
        keycode        = 8'h00;
        keycode_second = 8'h00;
        score_vec      = '0;
        miss_vec       = '0;
        step();
        step();
        Reset = 1'b0;
        check_a("reset", 16'h0000, 12'd0, 12'd0, 12'd0);
        check("reset.play", 32'(w_play_a), 32'd0);
        check("reset.over", 32'(w_over_a), 32'd0);

        // Stale levels in Idle must not count once play starts
        score_vec[40] = 1'b1;
        step();
        keycode = 8'h2c;
        step();
        keycode = 8'h00;
        check("start.play", 32'(w_play_a), 32'd1);
        for (int i = 0; i < 9; i++) step();
        check_a("quiet", 16'h0000, 12'd0, 12'd0, 12'd0);

        score_vec[3] = 1'b1;
        step();
        check_a("hit3", 16'h0010, 12'd1, 12'd1, 12'd1);
        for (int i = 0; i < 9; i++) begin
            step();
            check_a("hold3", 16'h0010, 12'd1, 12'd1, 12'd1);
        end

        score_vec[0] = 1'b1; score_vec[5] = 1'b1; score_vec[9] = 1'b1;
        step();
        check_a("multi", 16'h0040, 12'd4, 12'd4, 12'd4);

        miss_vec[7] = 1'b1;
        step();
        check_a("miss7", 16'h0040, 12'd4, 12'd0, 12'd4);

        score_vec[11] = 1'b1;
        step();
        check_a("after_miss", 16'h0050, 12'd5, 12'd1, 12'd4);

        score_vec[1] = 1'b1; miss_vec[2] = 1'b1;
        step();
        check_a("hit_and_miss", 16'h0060, 12'd6, 12'd0, 12'd4);

        score_vec[12] = 1'b1; miss_vec[12] = 1'b1;
        step();
        check_a("same_lane", 16'h0070, 12'd7, 12'd0, 12'd4);

        score_vec[17:13] = 5'b11111;
        step();
        check_a("new_max", 16'h0120, 12'd12, 12'd5, 12'd5);

        score_vec = '0; miss_vec = '0;
        step();
        check_a("fall", 16'h0120, 12'd12, 12'd5, 12'd5);

        for (int r = 0; r < 15; r++) begin
            score_vec = '1;
            step();
            score_vec = '0;
            step();
        end
        check_a("rounds", 16'h9720, 12'd972, 12'd965, 12'd965);

        score_vec = 64'h0000_0000_07FF_FFFF;
        step();
        check_a("near_max", 16'h9990, 12'd999, 12'd992, 12'd992);
        score_vec = '0;
        step();

        score_vec[0] = 1'b1;
        step();
        check_a("sat1", 16'h9999, 12'd1000, 12'd993, 12'd993);
        score_vec[1] = 1'b1;
        step();
        check_a("sat2", 16'h9999, 12'd1001, 12'd994, 12'd994);

        keycode = 8'h01;
        step();
        keycode = 8'h00;
        check("stop_in_play", 32'(w_play_a), 32'd1);
        check("stop_in_play.bcd", 32'(w_bcd_a), 32'h9999);

        // Short song: start via the secondary key
        score_vec = '0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_b("short_reset", 16'h0000, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0);
        keycode_second = 8'h2c;
        step();
        keycode_second = 8'h00;
        check("short_start", 32'(w_play_b), 32'd1);
        for (int i = 0; i < 15; i++) step();
        check_b("frame15", 16'h0000, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0);
        score_vec[0] = 1'b1;
        step();
        check_b("done", 16'h0010, 12'd1, 12'd1, 12'd1, 1'b0, 1'b1);

        score_vec[1] = 1'b1;
        keycode = 8'h2c;
        step();
        keycode = 8'h00;
        check_b("done_frozen", 16'h0010, 12'd1, 12'd1, 12'd1, 1'b0, 1'b1);

        keycode = 8'h01;
        step();
        keycode = 8'h00;
        check_b("back_idle", 16'h0000, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0);

        score_vec = '0;
        keycode = 8'h2c;
        step();
        keycode = 8'h00;
        score_vec[2] = 1'b1;
        step();
        check_b("replay_hit", 16'h0010, 12'd1, 12'd1, 12'd1, 1'b1, 1'b0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_b("mid_reset", 16'h0000, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
